// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared definitions for the UART receiver:
//     UART_CLKS_PER_BIT : default clk cycles per serial bit (50 MHz / 115200)
//     UART_DATA_BITS    : data bits per frame (LSB first)
//     rx_state_t        : receiver FSM state encoding (3 bits)
//     maj3()            : 2-of-3 majority vote used for bit sampling
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int UART_CLKS_PER_BIT = 434;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_IDLE = 3'd4
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
//   Receiver-to-arbiter handshake bundle.
//     rxAck    : arbiter grant; consumes the held byte when readyRx=1
//     readyRx  : an unconsumed byte is held on rxData
//     rxData   : received byte, stable while readyRx=1
//     frameErr : one-cycle pulse, stop bit sampled 0
//     overrun  : one-cycle pulse, frame completed while a byte was still held
//   Modports:
//     slave  - the receiver (drives data/flags, reads rxAck)
//     master - the arbiter  (reads data/flags, drives rxAck)
// -----------------------------------------------------------------------------
interface uart_rx_if
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
) ();

    logic                 rxAck;
    logic                 readyRx;
    logic [DATA_BITS-1:0] rxData;
    logic                 frameErr;
    logic                 overrun;

    modport slave (
        input  rxAck,
        output readyRx,
        output rxData,
        output frameErr,
        output overrun
    );

    modport master (
        output rxAck,
        input  readyRx,
        input  rxData,
        input  frameErr,
        input  overrun
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// -----------------------------------------------------------------------------
// uart_rx_sync_2ff
//   Two-flop synchronizer, one independent chain per bit.
//     clk   : destination clock
//     rst_n : asynchronous active-low reset; both flops load RESET_VAL
//     d     : asynchronous input
//     q     : synchronized output (2 clk latency)
// -----------------------------------------------------------------------------
module uart_rx_sync_2ff #(
    parameter int   WIDTH     = 1,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= RESET_VAL;
                    sync_reg <= RESET_VAL;
                end else begin
                    meta_reg <= d[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign q[gi] = sync_reg;
        end
    endgenerate

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   8N1 UART receiver with a one-byte holding register and arbiter handshake.
//     clk     : system clock
//     reset_n : asynchronous active-low reset (release is synchronized here)
//     rx      : serial line, idle high, asynchronous to clk
//     bus     : uart_rx_if.slave (rxAck in; readyRx, rxData, frameErr,
//               overrun out)
//   Each bit is sampled at MID-1, MID and MID+1 of its bit period and the
//   majority value is used. A received byte is held with readyRx until the
//   arbiter acks it.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      rx,
    uart_rx_if.slave  bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int MID   = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_SMP0 = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_SMP1 = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_EVAL = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    // Reset: asserts asynchronously, releases two clocks after reset_n rises.
    logic rst_n_sync;

    uart_rx_sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_rst_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (1'b1),
        .q     (rst_n_sync)
    );

    // Serial input synchronizer, preset to the idle (high) level.
    logic rxs;

    uart_rx_sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n_sync),
        .d     (rx),
        .q     (rxs)
    );

    rx_state_t            state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [IDX_W-1:0]     bit_idx_reg;
    logic [1:0]           samp_reg;
    logic [DATA_BITS-1:0] shreg_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 ready_reg;
    logic                 frame_err_reg;
    logic                 overrun_reg;

    // The third sample is the live rxs at CNT_EVAL, so the vote is available
    // in the same cycle it is used.
    logic bit_val;
    assign bit_val = maj3(samp_reg[0], samp_reg[1], rxs);

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_reg     <= RX_IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            samp_reg      <= 2'b11;
            shreg_reg     <= '0;
            data_reg      <= '0;
            ready_reg     <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            cnt_reg       <= cnt_reg + CNT_W'(1);

            // Consumption by the arbiter; a completing frame below may
            // re-assert readyRx on the same edge.
            if (ready_reg && bus.rxAck) begin
                ready_reg <= 1'b0;
            end

            if (cnt_reg == CNT_SMP0) begin
                samp_reg[0] <= rxs;
            end
            if (cnt_reg == CNT_SMP1) begin
                samp_reg[1] <= rxs;
            end

            case (state_reg)
                RX_IDLE: begin
                    cnt_reg <= '0;
                    if (!rxs) begin
                        state_reg <= RX_START;
                    end
                end

                RX_START: begin
                    if (cnt_reg == CNT_EVAL && bit_val) begin
                        // Line was back high mid-bit: treat as a glitch.
                        state_reg <= RX_IDLE;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg   <= RX_DATA;
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                    end
                end

                RX_DATA: begin
                    if (cnt_reg == CNT_EVAL) begin
                        shreg_reg[bit_idx_reg] <= bit_val;
                    end
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == IDX_LAST) begin
                            state_reg <= RX_STOP;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        end
                    end
                end

                RX_STOP: begin
                    // Decided mid-stop-bit so the next start edge can be
                    // caught during the second half of the stop bit.
                    if (cnt_reg == CNT_EVAL) begin
                        cnt_reg <= '0;
                        if (bit_val) begin
                            state_reg <= RX_IDLE;
                            // An ack in this very cycle frees the holding
                            // register, so the new byte loads without overrun.
                            if (!ready_reg || bus.rxAck) begin
                                data_reg  <= shreg_reg;
                                ready_reg <= 1'b1;
                            end else begin
                                overrun_reg <= 1'b1;
                            end
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= RX_WAIT_IDLE;
                        end
                    end
                end

                RX_WAIT_IDLE: begin
                    // A held-low line (break) must not be read as start bits.
                    cnt_reg <= '0;
                    if (rxs) begin
                        state_reg <= RX_IDLE;
                    end
                end

                default: begin
                    state_reg <= RX_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    assign bus.readyRx  = ready_reg;
    assign bus.rxData   = data_reg;
    assign bus.frameErr = frame_err_reg;
    assign bus.overrun  = overrun_reg;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx with CLKS_PER_BIT=16. Frames are driven
//   bit by bit on the falling clock edge; expected outputs come from a
//   frame-level model (held byte, ready flag, pulse and fall counts).
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic clk;
    logic reset_n;
    logic rx;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed event counts
    int   fe_cnt     = 0;
    int   ov_cnt     = 0;
    int   fall_cnt   = 0;
    logic prev_ready = 1'b0;
    time  rise_time  = 0;

    // Reference model state
    logic       exp_ready = 1'b0;
    logic [7:0] exp_data  = 8'h00;
    int         exp_fe    = 0;
    int         exp_ov    = 0;
    int         exp_falls = 0;

    always @(negedge clk) begin
        if (bus.frameErr === 1'b1) fe_cnt <= fe_cnt + 1;
        if (bus.overrun === 1'b1)  ov_cnt <= ov_cnt + 1;
        if (prev_ready && !bus.readyRx) fall_cnt <= fall_cnt + 1;
        if (!prev_ready && bus.readyRx) rise_time <= $time;
        prev_ready <= bus.readyRx;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level rule: good stop loads the byte unless one is still held
    // (an ack in the completing cycle frees it); bad stop only flags.
    task automatic model_frame(input logic [7:0] b, input bit good, input bit ack_same);
        if (!good) begin
            exp_fe++;
        end else if (!exp_ready || ack_same) begin
            exp_ready = 1'b1;
            exp_data  = b;
        end else begin
            exp_ov++;
        end
    endtask

    // Drives start, 8 data bits LSB first, then stop_bits bit times of the
    // stop level. ack_at pulses rxAck at that cycle; cut_at returns early.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int stop_bits,
                              input int ack_at, input int cut_at);
        int   nb;
        int   c;
        logic v;
        nb = 9 + stop_bits;
        for (int i = 0; i < nb; i++) begin
            if (i == 0)      v = 1'b0;
            else if (i <= 8) v = b[i-1];
            else             v = stop_ok;
            for (int j = 0; j < CPB; j++) begin
                c = i * CPB + j;
                if (c == cut_at) return;
                rx        = v;
                bus.rxAck = (c == ack_at);
                @(negedge clk);
            end
        end
        bus.rxAck = 1'b0;
        rx        = 1'b1;
    endtask

    task automatic ack();
        bus.rxAck = 1'b1;
        @(negedge clk);
        bus.rxAck = 1'b0;
        if (exp_ready) begin
            exp_ready = 1'b0;
            exp_falls++;
        end
        chk("ack_ready", 32'(bus.readyRx), 32'(exp_ready));
        chk("ack_data", 32'(bus.rxData), 32'(exp_data));
        @(negedge clk);
    endtask

    task automatic post_checks(input string tag);
        chk({tag, "_ready"}, 32'(bus.readyRx), 32'(exp_ready));
        chk({tag, "_data"},  32'(bus.rxData),  32'(exp_data));
        chk({tag, "_ferr"},  32'(fe_cnt),      32'(exp_fe));
        chk({tag, "_ovr"},   32'(ov_cnt),      32'(exp_ov));
        chk({tag, "_falls"}, 32'(fall_cnt),    32'(exp_falls));
        $display("frame %s: ready=%0b data=%02h ferr=%0d ovr=%0d",
                 tag, bus.readyRx, bus.rxData, fe_cnt, ov_cnt);
    endtask

    initial begin
        time        t0;
        logic [7:0] b;
        bit         good;
        int         gap;

        reset_n   = 1'b0;
        rx        = 1'b1;
        bus.rxAck = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.readyRx),  32'd0);
        chk("rst_data",  32'(bus.rxData),   32'd0);
        chk("rst_ferr",  32'(bus.frameErr), 32'd0);
        chk("rst_ovr",   32'(bus.overrun),  32'd0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // Clean frame, hold until ack, then fall with data retained
        t0 = $time;
        send_frame(8'hA5, 1'b1, 1, -1, -1);
        model_frame(8'hA5, 1'b1, 1'b0);
        chk("rise_delay", 32'((rise_time - t0) / 10), 32'd157);
        post_checks("a5");
        repeat ($urandom_range(3, 20)) @(negedge clk);
        chk("hold_ready", 32'(bus.readyRx), 32'd1);
        chk("hold_data",  32'(bus.rxData),  32'hA5);
        ack();

        // Glitch shorter than half a bit
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        post_checks("glitch");

        // Framing error with stop held low, then recovery
        send_frame(8'h3C, 1'b0, 3, -1, -1);
        model_frame(8'h3C, 1'b0, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        post_checks("ferr");
        send_frame(8'h11, 1'b1, 1, -1, -1);
        model_frame(8'h11, 1'b1, 1'b0);
        post_checks("11");
        ack();

        // Back-to-back frames without ack
        send_frame(8'h55, 1'b1, 1, -1, -1);
        model_frame(8'h55, 1'b1, 1'b0);
        post_checks("55");
        send_frame(8'h66, 1'b1, 1, -1, -1);
        model_frame(8'h66, 1'b1, 1'b0);
        post_checks("66_ovr");
        ack();

        // Ack on the exact completion cycle of the next frame
        send_frame(8'h12, 1'b1, 1, -1, -1);
        model_frame(8'h12, 1'b1, 1'b0);
        post_checks("12");
        repeat (CPB) @(negedge clk);
        send_frame(8'h34, 1'b1, 1, 156, -1);
        model_frame(8'h34, 1'b1, 1'b1);
        post_checks("34_coll");

        // Reset during data bit 4
        send_frame(8'hFF, 1'b1, 1, -1, 5 * CPB + 8);
        reset_n = 1'b0;
        #1;
        chk("mrst_ready", 32'(bus.readyRx), 32'd0);
        chk("mrst_data",  32'(bus.rxData),  32'd0);
        if (exp_ready) exp_falls++;
        exp_ready = 1'b0;
        exp_data  = 8'h00;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        post_checks("after_rst");
        send_frame(8'h81, 1'b1, 1, -1, -1);
        model_frame(8'h81, 1'b1, 1'b0);
        post_checks("81");

        // Randomized frames, gaps, stop errors and acks
        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            gap  = $urandom_range(0, 2);
            if (!good) gap = gap + 1;
            if ($urandom_range(0, 1) == 1) ack();
            send_frame(b, good, 1, -1, -1);
            model_frame(b, good, 1'b0);
            post_checks($sformatf("rnd%0d", k));
            repeat (gap * CPB) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
